gray_stream_decoder: RTL and testbench

Receive-side decoder for the gray-slot-multiplexed feedback bitstream. The transmitter serializes a 10-bit counter field one bit per external clock, choosing the bit by which gray-counter bit toggles in that cycle. This block runs a phase counter aligned to the transmitter's gray counter, demultiplexes each stream sample back into its bit position, and emits the reconstructed word once per 2048-cycle frame. It also emits a ones-density count and a consistency flag. It sits at the digital back-end, clocked by the same external clock as the transmitter's gray counter.

---
 rtl/gray_stream_decoder_pkg.sv | 12 +
 rtl/gray_stream_decoder_if.sv | 28 ++
 rtl/gray_stream_decoder_slot.sv | 24 ++
 rtl/gray_stream_decoder.sv | 109 ++++++++++
 tb/tb_gray_stream_decoder.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/gray_stream_decoder_pkg.sv
// Shared defaults and slot-to-bit mapping for the gray-slot feedback stream decoder.
package gray_stream_decoder_pkg;

  localparam int SLOTS_DEF   = 10;
  localparam int PHASE_W_DEF = SLOTS_DEF + 1;

  // Slot 1 is the most frequent toggle and carries the word MSB.
  function automatic int slot_to_bit(input int slots, input int s);
    return slots - s;
  endfunction

endpackage

// File: rtl/gray_stream_decoder_if.sv
// Stream input and decoded-word output bundle of gray_stream_decoder.
interface gray_stream_decoder_if
  import gray_stream_decoder_pkg::*;
#(
  parameter int SLOTS   = SLOTS_DEF,
  parameter int PHASE_W = PHASE_W_DEF
);

  logic               en;
  logic               sync;
  logic               stream_in;
  logic [SLOTS-1:0]   word_out;
  logic               word_valid;
  logic [PHASE_W-1:0] ones_out;
  logic               conflict;
  logic [PHASE_W-1:0] phase;

  modport master (
    output en, sync, stream_in,
    input  word_out, word_valid, ones_out, conflict, phase
  );

  modport slave (
    input  en, sync, stream_in,
    output word_out, word_valid, ones_out, conflict, phase
  );

endinterface

// File: rtl/gray_stream_decoder_slot.sv
// Combinational slot decode: s = trailing zeros of (p+1) evaluated on PHASE_W+1 bits.
module gray_slot_decode #(
  parameter int SLOTS   = 10,
  parameter int PHASE_W = 11,
  parameter int SW      = 4
) (
  input  logic [PHASE_W-1:0] p_i,
  output logic [SW-1:0]      s_o,
  output logic               slot_valid_o
);

  logic [PHASE_W:0] q;

  // Scanning downward leaves the lowest set bit of p+1 in s_o.
  always_comb begin
    q = {1'b0, p_i} + (PHASE_W+1)'(1);
    s_o = '0;
    for (int i = PHASE_W; i >= 0; i--) begin
      if (q[i]) s_o = SW'(i);
    end
    slot_valid_o = (s_o != '0) && (int'(s_o) <= SLOTS);
  end

endmodule

// File: rtl/gray_stream_decoder.sv
// Demultiplexes the gray-slot feedback stream back into a SLOTS-bit word once per frame,
// with a ones-density count and a repeated-sample consistency flag.
module gray_stream_decoder
  import gray_stream_decoder_pkg::*;
#(
  parameter int SLOTS   = SLOTS_DEF,
  parameter int PHASE_W = PHASE_W_DEF
) (
  input  logic                  clk,
  input  logic                  rstb,
  gray_stream_decoder_if.slave  bus
);

  localparam int SW = $clog2(PHASE_W + 1);
  localparam int BW = $clog2(SLOTS);

  logic [PHASE_W-1:0] phase_q;
  logic [SLOTS-1:0]   shadow_q, shadow_d;
  logic [SLOTS-1:0]   seen_q, seen_d;
  logic [PHASE_W-1:0] ones_q, ones_d;
  logic               conf_q, conf_d;
  logic [SLOTS-1:0]   word_out_q;
  logic [PHASE_W-1:0] ones_out_q;
  logic               conflict_q;
  logic               word_valid_q;

  logic [PHASE_W-1:0] p_cur;
  logic [SW-1:0]      slot;
  logic               slot_vld;
  logic [BW-1:0]      bidx;
  logic               frame_end;

  // A full frame of ones would be 2^PHASE_W; clamp instead of wrapping to zero.
  function automatic logic [PHASE_W-1:0] sat_inc(input logic [PHASE_W-1:0] a, input logic inc);
    if (inc && (a != '1)) return a + PHASE_W'(1);
    return a;
  endfunction

  assign p_cur     = bus.sync ? '0 : phase_q;
  assign frame_end = bus.en && !bus.sync && (phase_q == '1);
  assign bidx      = BW'(slot_to_bit(SLOTS, int'(slot)));

  gray_slot_decode #(
    .SLOTS   (SLOTS),
    .PHASE_W (PHASE_W),
    .SW      (SW)
  ) u_slot (
    .p_i          (p_cur),
    .s_o          (slot),
    .slot_valid_o (slot_vld)
  );

  // Sync restarts the frame in this same cycle, so accumulators start from zero.
  always_comb begin
    shadow_d = bus.sync ? '0 : shadow_q;
    seen_d   = bus.sync ? '0 : seen_q;
    conf_d   = bus.sync ? 1'b0 : conf_q;
    ones_d   = sat_inc(bus.sync ? '0 : ones_q, bus.stream_in);
    if (slot_vld) begin
      if (!seen_d[bidx]) begin
        shadow_d[bidx] = bus.stream_in;
        seen_d[bidx]   = 1'b1;
      end else if (shadow_d[bidx] != bus.stream_in) begin
        conf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      phase_q      <= '0;
      shadow_q     <= '0;
      seen_q       <= '0;
      ones_q       <= '0;
      conf_q       <= 1'b0;
      word_out_q   <= '0;
      ones_out_q   <= '0;
      conflict_q   <= 1'b0;
      word_valid_q <= 1'b0;
    end else begin
      word_valid_q <= 1'b0;
      if (bus.en) begin
        phase_q <= p_cur + PHASE_W'(1);
        if (frame_end) begin
          word_out_q   <= shadow_d;
          ones_out_q   <= ones_d;
          conflict_q   <= conf_d;
          word_valid_q <= 1'b1;
          shadow_q     <= '0;
          seen_q       <= '0;
          ones_q       <= '0;
          conf_q       <= 1'b0;
        end else begin
          shadow_q <= shadow_d;
          seen_q   <= seen_d;
          ones_q   <= ones_d;
          conf_q   <= conf_d;
        end
      end
    end
  end

  assign bus.word_out   = word_out_q;
  assign bus.word_valid = word_valid_q;
  assign bus.ones_out   = ones_out_q;
  assign bus.conflict   = conflict_q;
  assign bus.phase      = phase_q;

endmodule

// File: tb/tb_gray_stream_decoder.sv
// Directed bench for gray_stream_decoder: transmitter model drives the stream, a scoreboard checks each frame word.
module tb_gray_stream_decoder;

  localparam int SLOTS = 10;
  localparam int PW    = 11;
  localparam int FRAME = 2048;

  typedef struct {
    logic [9:0]  w;
    logic [10:0] ones;
    logic        c;
    int          at;
  } exp_t;

  logic clk = 1'b0;
  logic rstb;
  always #5 clk = ~clk;

  gray_stream_decoder_if #(.SLOTS(SLOTS), .PHASE_W(PW)) bus ();

  gray_stream_decoder #(.SLOTS(SLOTS), .PHASE_W(PW)) dut (
    .clk  (clk),
    .rstb (rstb),
    .bus  (bus)
  );

  exp_t       sb[$];
  int         n_asrt = 0;
  int         n_fail = 0;
  int         cyc    = 0;
  int         tp     = 0;
  logic [9:0] field_lo, field_hi;
  int         split;
  bit         all_ones;

  // Transmitter view: which bit of the (PW+1)-bit gray count toggles going from p to p+1.
  function automatic int toggled_bit(input int p);
    logic [11:0] a, b, ga, gb, d;
    a  = 12'(p);
    b  = 12'(p + 1);
    ga = a ^ (a >> 1);
    gb = b ^ (b >> 1);
    d  = ga ^ gb;
    for (int i = 0; i < 12; i++) if (d[i]) return i;
    return -1;
  endfunction

  function automatic logic tx_bit(input int p);
    int         k;
    logic [9:0] f;
    if (all_ones) return 1'b1;
    k = toggled_bit(p);
    if (k >= 1 && k <= SLOTS) begin
      f = (p < split) ? field_lo : field_hi;
      return f[SLOTS-k];
    end
    return 1'b0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (step %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step(input bit sy, input bit e);
    int   pc;
    exp_t x;
    cyc++;
    pc = sy ? 0 : tp;
    bus.en        = e;
    bus.sync      = sy;
    bus.stream_in = tx_bit(pc);
    @(posedge clk);
    #1;
    if (!rstb) tp = 0;
    else if (e) tp = (pc + 1) % FRAME;
    chk("phase", 32'(bus.phase), 32'(tp));
    if (bus.word_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", 32'(bus.word_valid), 32'd0);
      end else begin
        x = sb.pop_front();
        chk("word_out", 32'(bus.word_out), 32'(x.w));
        chk("ones_out", 32'(bus.ones_out), 32'(x.ones));
        chk("conflict", 32'(bus.conflict), 32'(x.c));
        chk("valid_step", 32'(cyc), 32'(x.at));
      end
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_word"},  32'(bus.word_out),   32'd0);
    chk({tag, "_ones"},  32'(bus.ones_out),   32'd0);
    chk({tag, "_conf"},  32'(bus.conflict),   32'd0);
    chk({tag, "_valid"}, 32'(bus.word_valid), 32'd0);
  endtask

  task automatic set_field(input logic [9:0] f);
    field_lo = f;
    field_hi = f;
    split    = FRAME;
  endtask

  initial begin
    rstb          = 1'b0;
    bus.en        = 1'b0;
    bus.sync      = 1'b0;
    bus.stream_in = 1'b0;
    all_ones      = 1'b0;
    set_field(10'h000);

    step(0, 1);
    step(0, 1);
    chk_outputs_zero("reset");
    rstb = 1'b1;

    // Field 0x2A5 aligned by sync, zeros in non-data cycles.
    set_field(10'h2A5);
    sb.push_back('{10'h2A5, 11'h2A5, 1'b0, cyc + FRAME});
    step(1, 1);
    repeat (FRAME - 1) step(0, 1);

    // Constant ones: ones count clamps at 2047.
    all_ones = 1'b1;
    sb.push_back('{10'h3FF, 11'd2047, 1'b0, cyc + FRAME});
    repeat (FRAME) step(0, 1);
    all_ones = 1'b0;

    // Field changes at mid-frame: slot 1 disagrees at p=1025.
    field_lo = 10'h200;
    field_hi = 10'h000;
    split    = 1024;
    sb.push_back('{10'h200, 11'd256, 1'b1, cyc + FRAME});
    repeat (FRAME) step(0, 1);

    // en held low for 50 cycles mid-frame.
    set_field(10'h155);
    sb.push_back('{10'h155, 11'h155, 1'b0, cyc + FRAME + 50});
    repeat (700) step(0, 1);
    repeat (50) step(0, 0);
    repeat (FRAME - 700) step(0, 1);

    // Sync at p=1000 discards the partial 0x3C3 frame.
    set_field(10'h3C3);
    repeat (1000) step(0, 1);
    set_field(10'h0F0);
    sb.push_back('{10'h0F0, 11'h0F0, 1'b0, cyc + FRAME});
    step(1, 1);
    repeat (FRAME - 1) step(0, 1);

    // Sync landing on the frame-end cycle suppresses that frame.
    set_field(10'h0AA);
    repeat (FRAME - 1) step(0, 1);
    sb.push_back('{10'h0AA, 11'h0AA, 1'b0, cyc + FRAME});
    step(1, 1);
    repeat (FRAME - 1) step(0, 1);

    // One-cycle reset at p=1500, then a full frame from p=0.
    set_field(10'h013);
    repeat (1500) step(0, 1);
    rstb = 1'b0;
    step(0, 1);
    chk_outputs_zero("midreset");
    rstb = 1'b1;
    sb.push_back('{10'h013, 11'h013, 1'b0, cyc + FRAME});
    repeat (FRAME) step(0, 1);
    repeat (4) step(0, 1);

    chk("pending_expect", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
